// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - multi-channel ASCII <letter><digits> command parser with K/? response register
module cmd_parser #(
  parameter int NUM_CH      = 4,
  parameter int DIGITS      = 3,
  parameter int VAL_W       = 10,
  parameter int MAX_VAL     = 999,
  parameter int TIMEOUT_CYC = 1200000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [NUM_CH*VAL_W-1:0] value,
  output logic [NUM_CH-1:0]       update,
  output logic [7:0]              err_cnt
);
  localparam int AW = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0]   MAX_V  = 32'(MAX_VAL);
  localparam logic [AW-1:0] TEN    = AW'(10);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] ch, ch_nx;
  logic [AW-1:0] acc, acc_nx;
  logic [KW-1:0] k, k_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          done_nx, rej_nx, tmo_ev_nx;

  // Events are registered once so every visible effect lands one edge after the byte.
  logic          ev_done, ev_rej, ev_tmo;
  logic [AW-1:0] ev_acc;
  logic [CW-1:0] ev_ch;

  logic [7:0] ldiff;
  logic       is_letter, is_digit;

  assign ldiff     = rx_data - 8'h53;
  assign is_letter = (rx_data >= 8'h53) && (ldiff < 8'(NUM_CH));
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      acc     <= '0;
      k       <= '0;
      tmo     <= '0;
      ev_done <= 1'b0;
      ev_rej  <= 1'b0;
      ev_tmo  <= 1'b0;
      ev_acc  <= '0;
      ev_ch   <= '0;
    end else begin
      state   <= state_nx;
      ch      <= ch_nx;
      acc     <= acc_nx;
      k       <= k_nx;
      tmo     <= tmo_nx;
      ev_done <= done_nx;
      ev_rej  <= rej_nx;
      ev_tmo  <= tmo_ev_nx;
      ev_acc  <= acc_nx;
      ev_ch   <= ch;
    end
  end

  always_comb begin
    state_nx  = state;
    ch_nx     = ch;
    acc_nx    = acc;
    k_nx      = k;
    tmo_nx    = tmo;
    done_nx   = 1'b0;
    rej_nx    = 1'b0;
    tmo_ev_nx = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && is_letter) begin
          state_nx = COLLECT;
          ch_nx    = ldiff[CW-1:0];
          acc_nx   = '0;
          k_nx     = '0;
          tmo_nx   = '0;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          tmo_nx = '0;
          if (is_digit) begin
            acc_nx = acc * TEN + AW'(rx_data[3:0]);
            if (k == K_LAST) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end else begin
              k_nx = k + 1'b1;
            end
          end else begin
            state_nx = IDLE;
            rej_nx   = 1'b1;
          end
        end else if (tmo == T_LAST) begin
          state_nx  = IDLE;
          tmo_ev_nx = 1'b1;
          tmo_nx    = '0;
        end else begin
          tmo_nx = tmo + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic       resp_ok, resp_new, err_inc;
  logic [7:0] resp_byte;

  always_comb begin
    resp_ok   = ev_done && (32'(ev_acc) <= MAX_V);
    resp_new  = ev_done || ev_rej;
    resp_byte = resp_ok ? 8'h4B : 8'h3F;
    err_inc   = ev_rej || ev_tmo || (ev_done && !resp_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      update   <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      err_cnt  <= 8'h00;
    end else begin
      update <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (resp_ok && ev_ch == CW'(i)) begin
          value[i*VAL_W +: VAL_W] <= VAL_W'(ev_acc);
          update[i]               <= 1'b1;
        end
      end
      // A handshake in the same cycle frees the slot; otherwise a new response is dropped.
      if (resp_new && (!tx_valid || tx_ready)) begin
        tx_valid <= 1'b1;
        tx_data  <= resp_byte;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (err_inc && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'h01;
    end
  end
endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - scoreboard bench for cmd_parser with a command-level reference model
module tb_cmd_parser;
  localparam int NCH  = 4;
  localparam int DIG  = 3;
  localparam int VW   = 10;
  localparam int MAXV = 500;
  localparam int TO   = 100;
  localparam int LET_S = 83;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic [NCH*VW-1:0] value;
  logic [NCH-1:0]    update;
  logic [7:0]        err_cnt;

  cmd_parser #(.NUM_CH(NCH), .DIGITS(DIG), .VAL_W(VW), .MAX_VAL(MAXV), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .value(value), .update(update), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct { int b; int cyc; } tx_e;
  typedef struct { int ch; int val; int cyc; } up_e;
  tx_e txq[$];
  up_e upq[$];

  // Reference model: a command is a letter then DIG digits; bytes carry their sample cycle.
  int m_collect = 0, m_ch = 0, m_acc = 0, m_nd = 0, m_last = 0, m_err = 0;
  int m_val[NCH];
  bit blk = 0, blk_pend = 0;

  task automatic m_err_inc();
    if (m_err < 255) m_err++;
  endtask

  task automatic m_resp(input int b, input int t);
    tx_e e;
    e.b = b;
    e.cyc = blk ? -1 : t + 1;
    if (!blk) txq.push_back(e);
    else if (!blk_pend) begin
      txq.push_back(e);
      blk_pend = 1;
    end
  endtask

  task automatic m_flush(input int t);
    if (m_collect != 0 && t - m_last > TO) begin
      m_collect = 0;
      m_err_inc();
    end
  endtask

  task automatic m_byte(input int b, input int t);
    up_e u;
    m_flush(t);
    if (m_collect == 0) begin
      if (b >= LET_S && b < LET_S + NCH) begin
        m_collect = 1; m_ch = b - LET_S; m_acc = 0; m_nd = 0; m_last = t;
      end
    end else begin
      m_last = t;
      if (b >= 48 && b <= 57) begin
        m_acc = m_acc * 10 + (b - 48);
        m_nd++;
        if (m_nd == DIG) begin
          m_collect = 0;
          if (m_acc <= MAXV) begin
            m_val[m_ch] = m_acc;
            u.ch = m_ch; u.val = m_acc; u.cyc = t + 1;
            upq.push_back(u);
            m_resp(75, t);
          end else begin
            m_resp(63, t);
            m_err_inc();
          end
        end
      end else begin
        m_collect = 0;
        m_resp(63, t);
        m_err_inc();
      end
    end
  endtask

  always @(negedge clk) begin
    tx_e te;
    up_e ue;
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_extra: got byte 0x%0h, required no response", tx_data);
        end else begin
          te = txq.pop_front();
          chk("tx_data", tx_data, te.b);
          if (te.cyc >= 0) chk("tx_cycle", cyc, te.cyc);
        end
      end
      if (update != '0) begin
        if (upq.size() == 0) begin
          checks++; errors++;
          $display("FAIL update_extra: got update 0x%0h, required none", update);
        end else begin
          ue = upq.pop_front();
          chk("update_mask", update, 1 << ue.ch);
          chk("update_value", value[ue.ch*VW +: VW], ue.val);
          chk("update_cycle", cyc, ue.cyc);
        end
      end
    end
  end

  task automatic step(input bit v, input int b);
    rx_valid = v;
    rx_data = 8'(b);
    if (v) m_byte(b, cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1, s[i]);
      repeat (gap) step(0, 0);
    end
  endtask

  task automatic rgap();
    int r;
    r = $urandom_range(0, 29);
    if (r == 0) repeat (TO - 1) step(0, 0);
    else if (r == 1) repeat (TO) step(0, 0);
    else if (r == 2) repeat (TO + 30) step(0, 0);
    else repeat ($urandom_range(0, 2)) step(0, 0);
  endtask

  task automatic settle(input string tag);
    longint expv;
    step(0, 0);
    step(0, 0);
    m_flush(cyc);
    expv = 0;
    for (int i = 0; i < NCH; i++) expv |= longint'(m_val[i]) << (i * VW);
    chk({tag, "_err_cnt"}, err_cnt, m_err);
    chk({tag, "_value"}, value, expv);
  endtask

  task automatic do_reset();
    rst = 1;
    rx_valid = 0;
    step(0, 0);
    step(0, 0);
    rst = 0;
    m_collect = 0; m_err = 0;
    for (int i = 0; i < NCH; i++) m_val[i] = 0;
    txq.delete();
    upq.delete();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) m_val[i] = 0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_value", value, 0);
    chk("rst_update", update, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_err_cnt", err_cnt, 0);

    send("S259", 3);   settle("s259");
    send("S0F7", 1);   settle("reject");
    send("U114", 0);   settle("u114");
    send("W350", 0);   settle("w_ignored");
    send("V350", 2);   settle("v350");
    send("S999", 0);   settle("over_max");
    send("S500", 0);   settle("at_max");
    send("S3", 0);
    repeat (TO) step(0, 0);
    settle("timeout");
    send("S350", 0);   settle("after_timeout");
    step(1, "S");
    repeat (TO - 1) step(0, 0);
    send("123", 0);    settle("byte_at_expiry");

    tx_ready = 0; blk = 1; blk_pend = 0;
    send("S111", 0);
    send("T222", 0);
    settle("backpressure");
    repeat (5) step(0, 0);
    chk("held_tx_valid", tx_valid, 1);
    chk("held_tx_data", tx_data, 8'h4B);
    tx_ready = 1;
    step(0, 0);
    blk = 0;
    chk("drained_tx_valid", tx_valid, 0);
    chk("drained_txq", txq.size(), 0);

    send("S2", 0);
    do_reset();
    step(0, 0);
    chk("midreset_tx_valid", tx_valid, 0);
    settle("midreset");

    for (int n = 0; n < 150; n++) begin
      int b;
      step(1, 81 + $urandom_range(0, 7));
      rgap();
      for (int d = 0; d < DIG; d++) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: b = 65;
            1: b = 47;
            2: b = 58;
            default: b = 13;
          endcase
        end else begin
          b = 48 + $urandom_range(0, 9);
        end
        step(1, b);
        rgap();
      end
      if (n % 25 == 24) settle("random");
    end
    settle("random_end");

    for (int n = 0; n < 300; n++) send("Sx", 0);
    settle("saturate");
    chk("sat_err_cnt", err_cnt, 255);
    chk("final_txq", txq.size(), 0);
    chk("final_upq", upq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
